// File: rtl/recibe_datos_pkg.sv
// Shared types and default constants for the recibe_datos serial receiver.
package recibe_datos_pkg;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    RECIBE = 2'd1,
    LLENO  = 2'd2
  } estado_t;

  localparam int ANCHO_DEF = 64;
  localparam int IDLE_DEF  = 512;
  localparam int SYNC_DEF  = 2;

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchronizer for one asynchronous input; every stage resets to 0.
module sincronizador
  import recibe_datos_pkg::*;
#(
  parameter int SYNC_ETAP = SYNC_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [SYNC_ETAP-1:0] cadena_r;

  generate
    if (SYNC_ETAP == 1) begin : g_uno
      // Single-stage capture of the asynchronous input.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          cadena_r <= 1'b0;
        end else begin
          cadena_r <= d;
        end
      end
    end else begin : g_varios
      // Shift the input through the synchronizer chain.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          cadena_r <= '0;
        end else begin
          cadena_r <= {cadena_r[SYNC_ETAP-2:0], d};
        end
      end
    end
  endgenerate

  assign q = cadena_r[SYNC_ETAP-1];

endmodule

// File: rtl/recibe_datos.sv
// Receiver for the gated-clock serial link: rebuilds LSB-first words and offers them on valido/acepta.
// Optional macro RECIBE_OVF_EN adds the sticky desborde output and keeps the unread word on overrun.
module recibe_datos
  import recibe_datos_pkg::*;
#(
  parameter int ANCHO     = ANCHO_DEF,
  parameter int IDLE_CYC  = IDLE_DEF,
  parameter int SYNC_ETAP = SYNC_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             DI,
  input  logic             SCLK,
  output logic [ANCHO-1:0] DATO,
  output logic             valido,
  input  logic             acepta,
  output logic             error_trama,
  output logic             ocupado
`ifdef RECIBE_OVF_EN
  ,
  output logic             desborde
`endif
);

  localparam int CW = $clog2(ANCHO + 1);
  localparam int TW = $clog2(IDLE_CYC + 1);
  localparam logic [CW-1:0] CUENTA_LLENA = CW'(ANCHO);
  localparam logic [CW-1:0] CUENTA_UNO   = CW'(1);
  localparam logic [CW-1:0] CUENTA_CERO  = CW'(0);
  localparam logic [TW-1:0] TIMER_FIN    = TW'(IDLE_CYC);
  localparam logic [TW-1:0] TIMER_UNO    = TW'(1);
  localparam logic [TW-1:0] TIMER_CERO   = TW'(0);

  logic             di_s;
  logic             sclk_s;
  logic             sclk_d_r;
  logic             flanco_s;
  logic [TW-1:0]    timer_r;
  logic [CW-1:0]    cuenta_r;
  logic [CW-1:0]    cuenta_sig_s;
  logic [ANCHO-2:0] sr_r;
  logic [ANCHO-1:0] palabra_s;
  estado_t          estado_r;
  estado_t          estado_sig_s;
  logic             desplaza_s;
  logic             completa_s;
  logic             descarta_s;
  logic             error_s;
  logic             se_pierde_s;

  sincronizador #(.SYNC_ETAP(SYNC_ETAP)) u_sync_di (
    .CLK (CLK),
    .RST (RST),
    .d   (DI),
    .q   (di_s)
  );

  sincronizador #(.SYNC_ETAP(SYNC_ETAP)) u_sync_sclk (
    .CLK (CLK),
    .RST (RST),
    .d   (SCLK),
    .q   (sclk_s)
  );

  assign flanco_s  = sclk_s & ~sclk_d_r;
  // sr_r holds the ANCHO-1 most recent bits; the bit being sampled completes the word.
  assign palabra_s = {di_s, sr_r};

  // Delayed copy of the synchronized bit clock for rising-edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_d_r <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
    end
  end

  // Idle timer: restarts on every bit-clock edge, saturates at IDLE_CYC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_r <= TIMER_CERO;
    end else if (flanco_s) begin
      timer_r <= TIMER_CERO;
    end else if (timer_r != TIMER_FIN) begin
      timer_r <= timer_r + TIMER_UNO;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Next-state and datapath control for the frame FSM.
  always_comb begin
    estado_sig_s = estado_r;
    cuenta_sig_s = cuenta_r;
    desplaza_s   = 1'b0;
    completa_s   = 1'b0;
    descarta_s   = 1'b0;
    error_s      = 1'b0;
    case (estado_r)
      REPOSO: begin
        if (flanco_s) begin
          estado_sig_s = RECIBE;
          cuenta_sig_s = CUENTA_UNO;
          desplaza_s   = 1'b1;
        end else begin
          estado_sig_s = REPOSO;
        end
      end
      RECIBE: begin
        if (flanco_s) begin
          desplaza_s = 1'b1;
          if (cuenta_r == (CUENTA_LLENA - CUENTA_UNO)) begin
            completa_s   = 1'b1;
            cuenta_sig_s = CUENTA_LLENA;
            estado_sig_s = LLENO;
          end else begin
            cuenta_sig_s = cuenta_r + CUENTA_UNO;
          end
        end else if (timer_r == TIMER_FIN) begin
          estado_sig_s = REPOSO;
          cuenta_sig_s = CUENTA_CERO;
          descarta_s   = 1'b1;
          error_s      = 1'b1;
        end else begin
          estado_sig_s = RECIBE;
        end
      end
      LLENO: begin
        // Padding edges after a complete word are ignored.
        if (timer_r == TIMER_FIN) begin
          estado_sig_s = REPOSO;
          cuenta_sig_s = CUENTA_CERO;
        end else begin
          estado_sig_s = LLENO;
        end
      end
      default: begin
        estado_sig_s = REPOSO;
        cuenta_sig_s = CUENTA_CERO;
      end
    endcase
  end

  // FSM state, bit count and the status outputs derived from them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      estado_r    <= REPOSO;
      cuenta_r    <= CUENTA_CERO;
      ocupado     <= 1'b0;
      error_trama <= 1'b0;
    end else begin
      estado_r    <= estado_sig_s;
      cuenta_r    <= cuenta_sig_s;
      ocupado     <= (estado_sig_s != REPOSO);
      error_trama <= error_s;
    end
  end

  // Shift register collecting the incoming bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sr_r <= '0;
    end else if (descarta_s) begin
      sr_r <= '0;
    end else if (desplaza_s) begin
      sr_r <= palabra_s[ANCHO-1:1];
    end else begin
      sr_r <= sr_r;
    end
  end

`ifdef RECIBE_OVF_EN
  assign se_pierde_s = completa_s & valido & ~acepta;

  // Sticky overrun flag, cleared by the consumer taking the word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      desborde <= 1'b0;
    end else if (se_pierde_s) begin
      desborde <= 1'b1;
    end else if (desborde && acepta) begin
      desborde <= 1'b0;
    end else begin
      desborde <= desborde;
    end
  end
`else
  assign se_pierde_s = 1'b0;
`endif

  // Output word register and valid/ack handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DATO   <= '0;
      valido <= 1'b0;
    end else if (completa_s && !se_pierde_s) begin
      DATO   <= palabra_s;
      valido <= 1'b1;
    end else if (completa_s) begin
      DATO   <= DATO;
      valido <= 1'b1;
    end else if (valido && acepta) begin
      DATO   <= DATO;
      valido <= 1'b0;
    end else begin
      DATO   <= DATO;
      valido <= valido;
    end
  end

endmodule

// File: tb/tb_recibe_datos.sv
// Self-checking bench for recibe_datos: directed and random frames against a word-level model.
module tb_recibe_datos;
  import recibe_datos_pkg::*;

  localparam int ANCHO = ANCHO_DEF;
  localparam int IDLE  = IDLE_DEF;
  localparam int SYNC  = SYNC_DEF;

  logic              CLK = 1'b0;
  logic              RST;
  logic              DI;
  logic              SCLK;
  logic              acepta;
  logic [ANCHO-1:0]  DATO;
  logic              valido;
  logic              error_trama;
  logic              ocupado;
`ifdef RECIBE_OVF_EN
  logic              desborde;
`endif

  recibe_datos #(.ANCHO(ANCHO), .IDLE_CYC(IDLE), .SYNC_ETAP(SYNC)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .DI          (DI),
    .SCLK        (SCLK),
    .DATO        (DATO),
    .valido      (valido),
    .acepta      (acepta),
    .error_trama (error_trama),
    .ocupado     (ocupado)
`ifdef RECIBE_OVF_EN
    ,
    .desborde    (desborde)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_subida = 0;
  int err_pulsos = 0;

  // Word-level reference model of the consumer-visible state.
  logic [ANCHO-1:0] m_dato;
  logic             m_valido;
  logic             m_desb;

  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (error_trama === 1'b1) err_pulsos <= err_pulsos + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected simulation end");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [ANCHO-1:0] obs, input logic [ANCHO-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_desb(input string tag);
`ifdef RECIBE_OVF_EN
    chk(tag, {{(ANCHO-1){1'b0}}, desborde}, {{(ANCHO-1){1'b0}}, m_desb});
`else
    m_desb = 1'b0;
`endif
  endtask

  function automatic void m_palabra(input logic [ANCHO-1:0] w, input logic ack);
`ifdef RECIBE_OVF_EN
    if (m_valido && !ack) m_desb = 1'b1;
    else begin
      m_dato = w;
      if (ack) m_desb = 1'b0;
    end
`else
    m_dato = w;
`endif
    m_valido = 1'b1;
  endfunction

  function automatic void m_acepta();
    m_valido = 1'b0;
    m_desb   = 1'b0;
  endfunction

  // One bit period: data changes with the falling bit clock, sampled mid-bit on the rise.
  task automatic bit_ciclo(input logic b);
    DI = b;
    SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    t_subida = cyc;
    repeat (4) @(negedge CLK);
    SCLK = 1'b0;
  endtask

  task automatic trama(input logic [ANCHO-1:0] w, input int n, input logic aleat);
    for (int i = 0; i < n; i++) begin
      if (i < ANCHO) bit_ciclo(w[i]);
      else if (aleat) bit_ciclo(1'($urandom_range(0, 1)));
      else bit_ciclo(1'b0);
    end
  endtask

  // Raises the clock for the last bit and stops right before the completing CLK edge.
  task automatic ultimo_bit(input logic b);
    DI = b;
    SCLK = 1'b0;
    repeat (4) @(negedge CLK);
    SCLK = 1'b1;
    t_subida = cyc;
    repeat (SYNC) @(negedge CLK);
  endtask

  task automatic terminar_bit();
    repeat (2) @(negedge CLK);
    SCLK = 1'b0;
  endtask

  task automatic pulso_acepta();
    @(negedge CLK);
    acepta = 1'b1;
    @(negedge CLK);
    acepta = 1'b0;
    m_acepta();
  endtask

  // Waits for the frame to close and checks the closing delay after the last edge.
  task automatic reposo(input string tag);
    int lat;
    lat = -1;
    SCLK = 1'b0;
    for (int k = 0; k < IDLE + 100; k++) begin
      @(negedge CLK);
      if (ocupado === 1'b0) begin
        lat = cyc - t_subida;
        break;
      end
    end
    chk(tag, ANCHO'(lat >= IDLE && lat <= IDLE + SYNC + 4), ANCHO'(1));
    repeat (4) @(negedge CLK);
  endtask

  task automatic estado(input string tag);
    chk({tag, "_dato"}, DATO, m_dato);
    chk({tag, "_valido"}, ANCHO'(valido), ANCHO'(m_valido));
    chk_desb({tag, "_desborde"});
  endtask

  initial begin
    logic [ANCHO-1:0] w;
    logic [ANCHO-1:0] w2;
    int e0;
    int n;

    RST = 1'b1; DI = 1'b0; SCLK = 1'b0; acepta = 1'b0;
    m_dato = '0; m_valido = 1'b0; m_desb = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_dato", DATO, '0);
    chk("rst_valido", ANCHO'(valido), ANCHO'(0));
    chk("rst_error", ANCHO'(error_trama), ANCHO'(0));
    chk("rst_ocupado", ANCHO'(ocupado), ANCHO'(0));
    chk_desb("rst_desborde");
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Fixed pattern with latency check on the last edge.
    w = 64'hA5A5_0000_FFFF_1234;
    e0 = err_pulsos;
    trama(w, ANCHO - 1, 1'b0);
    ultimo_bit(w[ANCHO-1]);
    chk("t1_antes", ANCHO'(valido), ANCHO'(0));
    @(negedge CLK);
    chk("t1_latencia", ANCHO'(valido), ANCHO'(1));
    chk("t1_dato", DATO, w);
    terminar_bit();
    m_palabra(w, 1'b0);
    reposo("t1_fin");
    chk("t1_sin_error", ANCHO'(err_pulsos - e0), ANCHO'(0));
    estado("t1");
    pulso_acepta();
    estado("t1_acepta");

    // Sender-style burst: one word plus 321 zero padding bits.
    w = 64'h1;
    e0 = err_pulsos;
    trama(w, 385, 1'b0);
    m_palabra(w, 1'b0);
    chk("t2_ocupado", ANCHO'(ocupado), ANCHO'(1));
    estado("t2");
    reposo("t2_fin");
    chk("t2_sin_error", ANCHO'(err_pulsos - e0), ANCHO'(0));
    pulso_acepta();
    estado("t2_acepta");

    // Short frame then a good frame.
    w = 64'($urandom) << 32 | 64'($urandom);
    e0 = err_pulsos;
    trama(w, 40, 1'b0);
    reposo("t3_fin_corta");
    chk("t3_error_pulso", ANCHO'(err_pulsos - e0), ANCHO'(1));
    estado("t3_corta");
    w = 64'($urandom) << 32 | 64'($urandom);
    trama(w, ANCHO, 1'b0);
    m_palabra(w, 1'b0);
    reposo("t3_fin_buena");
    chk("t3_error_unico", ANCHO'(err_pulsos - e0), ANCHO'(1));
    estado("t3_buena");
    pulso_acepta();

    // Two frames with no acknowledge in between.
    w  = 64'($urandom) << 32 | 64'($urandom);
    w2 = ~w;
    trama(w, ANCHO, 1'b0);
    m_palabra(w, 1'b0);
    reposo("t4_fin1");
    trama(w2, ANCHO, 1'b0);
    m_palabra(w2, 1'b0);
    reposo("t4_fin2");
    estado("t4");
    pulso_acepta();
    estado("t4_acepta");

    // Acknowledge in the same cycle the next word completes.
    w  = 64'($urandom) << 32 | 64'($urandom);
    w2 = 64'($urandom) << 32 | 64'($urandom);
    trama(w, ANCHO, 1'b0);
    m_palabra(w, 1'b0);
    reposo("t5_fin1");
    trama(w2, ANCHO - 1, 1'b0);
    ultimo_bit(w2[ANCHO-1]);
    acepta = 1'b1;
    @(negedge CLK);
    acepta = 1'b0;
    m_palabra(w2, 1'b1);
    estado("t5");
    terminar_bit();
    reposo("t5_fin2");

    // Asynchronous reset in the middle of a frame.
    w = 64'($urandom) << 32 | 64'($urandom);
    trama(w, 20, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    m_dato = '0; m_valido = 1'b0; m_desb = 1'b0;
    chk("t6_ocupado", ANCHO'(ocupado), ANCHO'(0));
    estado("t6_rst");
    @(negedge CLK);
    RST = 1'b0;
    e0 = err_pulsos;
    for (int i = 20; i < ANCHO; i++) bit_ciclo(w[i]);
    reposo("t6_fin");
    chk("t6_error_pulso", ANCHO'(err_pulsos - e0), ANCHO'(1));
    estado("t6");

    // Random frames of random length with random padding and acknowledges.
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) pulso_acepta();
      w = 64'($urandom) << 32 | 64'($urandom);
      n = ($urandom_range(0, 1) == 1) ? $urandom_range(ANCHO, ANCHO + 30) : $urandom_range(1, ANCHO - 1);
      e0 = err_pulsos;
      trama(w, n, 1'b1);
      if (n >= ANCHO) m_palabra(w, 1'b0);
      reposo("rnd_fin");
      chk("rnd_error", ANCHO'(err_pulsos - e0), ANCHO'(n < ANCHO));
      estado("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
